// File: rtl/display_mux_relogio.sv
// Time-multiplexed 4-digit 7-segment driver for the BCD clock counters.
// Captures the four digits once per frame, and supports leading-zero blanking and minutes blink.
module display_mux_relogio #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLINK_DIV      = 250,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       scan_tick
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // Pin levels for the dark state, so reset and blanking share one definition.
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [3:0] AN_OFF  = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          scan_tick_q, scan_tick_d;

    logic [3:0]    sh_su_q, sh_su_d;
    logic [3:0]    sh_st_q, sh_st_d;
    logic [3:0]    sh_mu_q, sh_mu_d;
    logic [3:0]    sh_mt_q, sh_mt_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          tick;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler, slot index, scan tick
    // ------------------------------------------------------------------
    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        scan_tick_d = tick;
    end

    // ------------------------------------------------------------------
    // Frame-coherent capture: all digits load together as the scan wraps to slot 0
    // ------------------------------------------------------------------
    always_comb begin
        sh_su_d = sh_su_q;
        sh_st_d = sh_st_q;
        sh_mu_d = sh_mu_q;
        sh_mt_d = sh_mt_q;
        if (tick && (idx_q == 2'd3)) begin
            sh_su_d = sec_units;
            sh_st_d = sec_tens;
            sh_mu_d = min_units;
            sh_mt_d = min_tens;
        end
    end

    // ------------------------------------------------------------------
    // Blink timing; held at zero while disabled so a new blink starts visible
    // ------------------------------------------------------------------
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit select, blanking and pin polarity
    // ------------------------------------------------------------------
    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_hi;
    logic [3:0] an_hi;
    logic       dp_hi;

    always_comb begin
        digit = sh_su_q;
        unique case (idx_q)
            2'd0: digit = sh_su_q;
            2'd1: digit = sh_st_q;
            2'd2: digit = sh_mu_q;
            2'd3: digit = sh_mt_q;
        endcase

        blank = 1'b0;
        if (blank_lz && (idx_q == 2'd3) && (sh_mt_q == 4'd0)) begin
            blank = 1'b1;
        end
        // Slots 2 and 3 are the minutes digits.
        if (blink_en && phase_q && idx_q[1]) begin
            blank = 1'b1;
        end

        seg_hi = blank ? 7'h00 : bcd_to_seg(digit);
        an_hi  = blank ? 4'h0 : (4'b0001 << idx_q);
        dp_hi  = !blank && (idx_q == 2'd2);

        seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        an_d  = DIG_ACTIVE_LOW ? ~an_hi : an_hi;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            scan_tick_q <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sh_su_q     <= 4'd0;
            sh_st_q     <= 4'd0;
            sh_mu_q     <= 4'd0;
            sh_mt_q     <= 4'd0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            an_q        <= AN_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            scan_tick_q <= scan_tick_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sh_su_q     <= sh_su_d;
            sh_st_q     <= sh_st_d;
            sh_mu_q     <= sh_mu_d;
            sh_mt_q     <= sh_mt_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_display_mux_relogio.sv
// Bench for display_mux_relogio: stimulus queues expected per-slot pin states,
// a monitor pops and compares one entry each time a new slot is displayed.
module tb_display_mux_relogio;

    logic       clk;
    logic       clear;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       blank_lz, blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       scan_tick;

    display_mux_relogio #(
        .SCAN_DIV      (4),
        .BLINK_DIV     (2),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .sec_units(sec_units),
        .sec_tens (sec_tens),
        .min_units(min_units),
        .min_tens (min_tens),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .scan_tick(scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segment codes, hand-derived from the active-high patterns.
    localparam logic [6:0] C0 = 7'h40, C1 = 7'h79, C2 = 7'h24, C3 = 7'h30;
    localparam logic [6:0] C5 = 7'h12, C7 = 7'h78, C9 = 7'h10, CD = 7'h3F;
    localparam logic [6:0] OFF = 7'h7F;
    localparam logic [3:0] AN0 = 4'b1110, AN1 = 4'b1101, AN2 = 4'b1011, AN3 = 4'b0111;
    localparam logic [3:0] ANX = 4'b1111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   slots_seen = 0;
    logic st_seen = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: one cycle after each scan_tick the output register shows the new slot.
    always @(negedge clk) begin
        if (st_seen) begin
            slots_seen++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {20'd0, an, seg, dp}, {20'd0, e.an, e.seg, e.dp});
            end
        end
        st_seen = scan_tick;
    end

    task automatic step(input string nm, input logic [3:0] a, input logic [6:0] s,
                        input logic d);
        exp_t e;
        int   n0;
        int   waited;
        e.an = a; e.seg = s; e.dp = d; e.name = nm;
        exp_q.push_back(e);
        n0 = slots_seen;
        waited = 0;
        while (slots_seen == n0 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (slots_seen == n0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no slot advance, required one within 40 cycles", nm);
        end
    endtask

    initial begin
        int cnt;
        clear = 1'b0;
        sec_units = 4'd0; sec_tens = 4'd0; min_units = 4'd0; min_tens = 4'd0;
        blank_lz = 1'b0; blink_en = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        repeat (6) @(negedge clk);

        // Asynchronous clear in the middle of a scan
        clear = 1'b0;
        #1;
        check("reset_an", {28'd0, an}, {28'd0, ANX});
        check("reset_seg", {25'd0, seg}, {25'd0, OFF});
        check("reset_dp", {31'd0, dp}, 32'd1);
        check("reset_scan_tick", {31'd0, scan_tick}, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        cnt = 0;
        while (!scan_tick && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("first_tick_latency", cnt, 32'd4);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!scan_tick && cnt < 20);
        check("tick_period", cnt, 32'd4);

        // Clean restart with 12:53 on the inputs; shadow stays 0 until the first wrap
        clear = 1'b0;
        min_tens = 4'd1; min_units = 4'd2; sec_tens = 4'd5; sec_units = 4'd3;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        step("pre_cap_s1", AN1, C0, 1'b1);
        step("pre_cap_s2", AN2, C0, 1'b0);
        step("pre_cap_s3", AN3, C0, 1'b1);
        step("fa_s0", AN0, C3, 1'b1);
        step("fa_s1", AN1, C5, 1'b1);
        sec_units = 4'd9;
        min_units = 4'd7;
        step("fa_s2_hold", AN2, C2, 1'b0);
        min_tens = 4'hC;
        step("fa_s3_hold", AN3, C1, 1'b1);
        step("fb_s0_new", AN0, C9, 1'b1);
        step("fb_s1", AN1, C5, 1'b1);
        step("fb_s2_new", AN2, C7, 1'b0);
        step("fb_s3_dash", AN3, CD, 1'b1);
        min_tens = 4'd0;
        blank_lz = 1'b1;
        step("fc_s0", AN0, C9, 1'b1);
        step("fc_s1", AN1, C5, 1'b1);
        step("fc_s2", AN2, C7, 1'b0);
        step("fc_s3_lz_blank", ANX, OFF, 1'b1);
        blank_lz = 1'b0;
        step("fd_s0", AN0, C9, 1'b1);
        step("fd_s1", AN1, C5, 1'b1);
        step("fd_s2", AN2, C7, 1'b0);
        step("fd_s3_zero", AN3, C0, 1'b1);

        // Blink: enabled at slot 0, minutes go dark on alternate 2-tick halves
        step("fe_s0", AN0, C9, 1'b1);
        blink_en = 1'b1;
        step("fe_s1", AN1, C5, 1'b1);
        step("fe_s2_dark", ANX, OFF, 1'b1);
        step("fe_s3_dark", ANX, OFF, 1'b1);
        step("ff_s0", AN0, C9, 1'b1);
        step("ff_s1", AN1, C5, 1'b1);
        step("ff_s2_dark", ANX, OFF, 1'b1);
        step("ff_s3_dark", ANX, OFF, 1'b1);
        blink_en = 1'b0;
        @(negedge clk);
        check("unblink_an", {28'd0, an}, {28'd0, AN3});
        check("unblink_seg", {25'd0, seg}, {25'd0, C0});
        step("fg_s0", AN0, C9, 1'b1);
        step("fg_s1", AN1, C5, 1'b1);
        step("fg_s2", AN2, C7, 1'b0);
        step("fg_s3", AN3, C0, 1'b1);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
